hazard_ctrl: RTL

Pipeline sequencing controller for the 5-stage RV32I core. It tracks destination and source registers of instructions in flight in EX, MEM and WB using its own shadow pipeline. From that state it generates PC and IF/ID enables, IF/ID flush, ID/EX bubble insertion and EX-stage operand forwarding selects. It sits beside the opcode decoder: it consumes the decoder's regWrite/memRead control bits for the ID-stage instruction plus branch-redirect and data-memory-busy status from later stages.

---
 rtl/hazard_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing for the 5-stage RV32I core.
// A shadow copy of the EX/MEM/WB register-usage fields drives stall, flush,
// bubble and forwarding decisions for the instruction currently in ID.
// Optional feature macro: HAZARD_FWD_EN (EX-stage operand forwarding).
// When it is undefined, forwarding selects are tied to 00 and any in-flight
// producer in EX or MEM stalls the consumer in ID.
module hazard_ctrl #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [4:0]             id_rs1,
  input  logic [4:0]             id_rs2,
  input  logic                   id_use_rs1,
  input  logic                   id_use_rs2,
  input  logic [4:0]             id_rd,
  input  logic                   id_regwrite,
  input  logic                   id_memread,
  input  logic                   ex_redirect,
  input  logic                   mem_busy,
  output logic                   pc_en,
  output logic                   ifid_en,
  output logic                   ifid_flush,
  output logic                   idex_bubble,
  output logic [1:0]             fwd_a,
  output logic [1:0]             fwd_b,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  // shadow pipeline
  logic [4:0] ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
  logic       ex_wr, ex_ld, ex_u1, ex_u2;
  logic       mem_wr, mem_ld, wb_wr;

  logic use1, use2, hz1, hz2, hazard, ex_load;

  // a source index of x0 never creates a dependency
  assign use1 = id_use_rs1 & (id_rs1 != 5'd0);
  assign use2 = id_use_rs2 & (id_rs2 != 5'd0);

`ifdef HAZARD_FWD_EN
  // only a load still in EX cannot be forwarded in time
  assign hz1 = use1 & ex_wr & ex_ld & (ex_rd == id_rs1);
  assign hz2 = use2 & ex_wr & ex_ld & (ex_rd == id_rs2);

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic u,
                                         input logic mwr, input logic mld,
                                         input logic [4:0] mrd,
                                         input logic wwr, input logic [4:0] wrd);
    logic [1:0] s;
    s = 2'b00;
    if (u && rs != 5'd0) begin
      // a load result is never taken from EX/MEM; load-use stall moves it to WB
      if (mwr && !mld && mrd == rs) s = 2'b10;
      else if (wwr && wrd == rs)    s = 2'b01;
    end
    return s;
  endfunction

  assign fwd_a = fwd_sel(ex_rs1, ex_u1, mem_wr, mem_ld, mem_rd, wb_wr, wb_rd);
  assign fwd_b = fwd_sel(ex_rs2, ex_u2, mem_wr, mem_ld, mem_rd, wb_wr, wb_rd);
`else
  // no bypass: wait until the producer has reached WB (write-before-read RF)
  assign hz1 = use1 & ((ex_wr & (ex_rd == id_rs1)) | (mem_wr & (mem_rd == id_rs1)));
  assign hz2 = use2 & ((ex_wr & (ex_rd == id_rs2)) | (mem_wr & (mem_rd == id_rs2)));

  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;

  // fields kept for shadow-state parity with the forwarding build
  logic unused_shadow;
  assign unused_shadow = ^{ex_ld, ex_rs1, ex_rs2, ex_u1, ex_u2, mem_ld, wb_rd, wb_wr};
`endif

  assign hazard = id_valid & (hz1 | hz2);

  // priority: freeze > redirect squash > hazard stall > run
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (mem_busy) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
    end else if (ex_redirect) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (hazard) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  assign ex_load = id_valid & ~idex_bubble;

  // shadow advance; holds under freeze so pending hazards are re-evaluated
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rd  <= '0; ex_rs1 <= '0; ex_rs2 <= '0;
      ex_wr  <= 1'b0; ex_ld <= 1'b0; ex_u1 <= 1'b0; ex_u2 <= 1'b0;
      mem_rd <= '0; mem_wr <= 1'b0; mem_ld <= 1'b0;
      wb_rd  <= '0; wb_wr  <= 1'b0;
    end else if (!mem_busy) begin
      wb_rd  <= mem_rd;
      wb_wr  <= mem_wr;
      mem_rd <= ex_rd;
      mem_wr <= ex_wr;
      mem_ld <= ex_ld;
      ex_rd  <= ex_load ? id_rd  : 5'd0;
      ex_rs1 <= ex_load ? id_rs1 : 5'd0;
      ex_rs2 <= ex_load ? id_rs2 : 5'd0;
      ex_wr  <= ex_load & id_regwrite & (id_rd != 5'd0);
      ex_ld  <= ex_load & id_memread;
      ex_u1  <= ex_load & id_use_rs1;
      ex_u2  <= ex_load & id_use_rs2;
    end
  end

  // saturating count of cycles with the PC held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if (!pc_en && stall_cycles != '1)
      stall_cycles <= stall_cycles + STALL_CNT_W'(1);
  end

endmodule
